// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand-delivery stage: datapath widths,
// the logic-select encoding and the layout of one buffered operand entry.
package alu_operand_stage_pkg;

    localparam int BITS       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        LOGIC_XOR = 2'b00,
        LOGIC_OR  = 2'b01,
        LOGIC_AND = 2'b10
    } logic_sel_e;

    typedef struct packed {
        logic [BITS-1:0]       a;
        logic [BITS-1:0]       b;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic                  use_imm;
        logic_sel_e            sel;
        logic [REG_ADDR_W-1:0] rd;
    } operand_entry_t;

    // The unused select code 11 is folded onto AND so the logical unit
    // only ever sees one of its three defined operations.
    function automatic logic_sel_e norm_sel(input logic [1:0] s);
        return (s == 2'b11) ? LOGIC_AND : logic_sel_e'(s);
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side and logical-unit-side handshake bus of the operand stage.
// slave: the stage itself; master: the decode/consumer environment.
interface alu_operand_stage_if;
    import alu_operand_stage_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [REG_ADDR_W-1:0] in_rs1_addr;
    logic [REG_ADDR_W-1:0] in_rs2_addr;
    logic [BITS-1:0]       in_rs1_data;
    logic [BITS-1:0]       in_rs2_data;
    logic [BITS-1:0]       in_imm;
    logic                  in_use_imm;
    logic [1:0]            in_sel;
    logic [REG_ADDR_W-1:0] in_rd_addr;

    logic                  out_valid;
    logic                  out_ready;
    logic [BITS-1:0]       A;
    logic [BITS-1:0]       B;
    logic [1:0]            Sel;
    logic [REG_ADDR_W-1:0] out_rd_addr;

    modport slave (
        input  in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_sel, in_rd_addr, out_ready,
        output in_ready, out_valid, A, B, Sel, out_rd_addr
    );

    modport master (
        output in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_sel, in_rd_addr, out_ready,
        input  in_ready, out_valid, A, B, Sel, out_rd_addr
    );

endinterface

// File: rtl/alu_operand_stage_operand_fwd_mux.sv
// Forwarding substitution for one operand entry: replaces A and/or B with
// the forwarded value when the forwarding destination matches a source
// index. Register 0 is hardwired and never matches; an immediate B is
// never replaced.
module operand_fwd_mux
    import alu_operand_stage_pkg::*;
(
    input  operand_entry_t        cur,
    input  logic                  fwd_valid,
    input  logic [REG_ADDR_W-1:0] fwd_rd_addr,
    input  logic [BITS-1:0]       fwd_data,
    output operand_entry_t        nxt
);

    // Match each source index against the forwarding bus and substitute.
    always_comb begin
        nxt = cur;
        if (fwd_valid && (fwd_rd_addr != '0)) begin
            if (fwd_rd_addr == cur.rs1_addr) begin
                nxt.a = fwd_data;
            end
            if (!cur.use_imm && (fwd_rd_addr == cur.rs2_addr)) begin
                nxt.b = fwd_data;
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand-delivery stage in front of the 32-bit logical unit.
// A main register drives the outputs; a skid register absorbs one entry
// under back-pressure so in_ready depends only on registered state.
// Build option: define ALU_FWD_SNOOP_EN to keep forwarding into entries
// while they are held; otherwise forwarding applies only at capture.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  fwd_valid,
    input  logic [REG_ADDR_W-1:0] fwd_rd_addr,
    input  logic [BITS-1:0]       fwd_data,
    alu_operand_stage_if.slave    bus
);

`ifdef ALU_FWD_SNOOP_EN
    localparam logic SNOOP_EN = 1'b1;
`else
    localparam logic SNOOP_EN = 1'b0;
`endif

    operand_entry_t cap_raw, cap_p0;
    operand_entry_t main_p1, main_fwd;
    operand_entry_t skid_p1, skid_fwd;
    logic           vld_p1, skid_vld_p1;
    logic           accept, drain, hold_fwd_valid;

    assign bus.in_ready    = !rst && !flush && !skid_vld_p1;
    assign accept          = bus.in_valid && bus.in_ready;
    assign drain           = vld_p1 && bus.out_ready;
    assign hold_fwd_valid  = fwd_valid & SNOOP_EN;

    // Assemble the incoming entry: B selects immediate or rs2 value.
    always_comb begin
        cap_raw.a        = bus.in_rs1_data;
        cap_raw.b        = bus.in_use_imm ? bus.in_imm : bus.in_rs2_data;
        cap_raw.rs1_addr = bus.in_rs1_addr;
        cap_raw.rs2_addr = bus.in_rs2_addr;
        cap_raw.use_imm  = bus.in_use_imm;
        cap_raw.sel      = norm_sel(bus.in_sel);
        cap_raw.rd       = bus.in_rd_addr;
    end

    operand_fwd_mux u_fwd_cap (
        .cur(cap_raw), .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr),
        .fwd_data(fwd_data), .nxt(cap_p0)
    );

    operand_fwd_mux u_fwd_main (
        .cur(main_p1), .fwd_valid(hold_fwd_valid), .fwd_rd_addr(fwd_rd_addr),
        .fwd_data(fwd_data), .nxt(main_fwd)
    );

    operand_fwd_mux u_fwd_skid (
        .cur(skid_p1), .fwd_valid(hold_fwd_valid), .fwd_rd_addr(fwd_rd_addr),
        .fwd_data(fwd_data), .nxt(skid_fwd)
    );

    // --- stage p0 -> p1 boundary ---
    // Occupancy of main and skid; accept while skid is full cannot happen.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (drain) begin
            vld_p1      <= skid_vld_p1 || accept;
            skid_vld_p1 <= 1'b0;
        end else if (!vld_p1) begin
            vld_p1      <= accept;
        end else if (accept) begin
            skid_vld_p1 <= 1'b1;
        end
    end

    // Main entry: refill from skid first, else from capture, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_p1 <= '0;
        end else if (drain && skid_vld_p1) begin
            main_p1 <= skid_fwd;
        end else if (accept && (!vld_p1 || drain)) begin
            main_p1 <= cap_p0;
        end else begin
            main_p1 <= main_fwd;
        end
    end

    // Skid entry: loaded only when main is full and not draining.
    always_ff @(posedge clk) begin
        if (accept && vld_p1 && !drain) begin
            skid_p1 <= cap_p0;
        end else begin
            skid_p1 <= skid_fwd;
        end
    end

    assign bus.out_valid   = vld_p1;
    assign bus.A           = main_p1.a;
    assign bus.B           = main_p1.b;
    assign bus.Sel         = main_p1.sel;
    assign bus.out_rd_addr = main_p1.rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios followed by random
// traffic, with a queue-based reference of the at-most-two held entries.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        fwd_valid = 1'b0;
    logic [4:0]  fwd_rd_addr = '0;
    logic [31:0] fwd_data = '0;

    alu_operand_stage_if bus ();

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .fwd_valid(fwd_valid),
        .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data), .bus(bus.slave)
    );

    always #5 clk = ~clk;

`ifdef ALU_FWD_SNOOP_EN
    localparam bit SNOOP = 1'b1;
`else
    localparam bit SNOOP = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        bit          use_imm;
        logic [1:0]  sel;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd_pick(input logic [4:0] rs, input logic [31:0] v);
        if (fwd_valid && fwd_rd_addr != 5'd0 && fwd_rd_addr == rs) return fwd_data;
        return v;
    endfunction

    // Monitor and reference: compare outputs to the queue head, then
    // advance the queue to reflect the coming clock edge.
    always @(negedge clk) begin
        exp_t e;
        bit   acc;
        if (started) begin
            check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
            check("in_ready", 32'(bus.in_ready), 32'(!rst && !flush && q.size() < 2));
            if (bus.out_valid && q.size() > 0) begin
                check("A", bus.A, q[0].a);
                check("B", bus.B, q[0].b);
                check("Sel", 32'(bus.Sel), 32'(q[0].sel));
                check("rd", 32'(bus.out_rd_addr), 32'(q[0].rd));
            end
            if (rst || flush) begin
                q.delete();
            end else begin
                acc = bus.in_valid && q.size() < 2;
                if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
                if (SNOOP) begin
                    foreach (q[i]) begin
                        q[i].a = fwd_pick(q[i].rs1, q[i].a);
                        if (!q[i].use_imm) q[i].b = fwd_pick(q[i].rs2, q[i].b);
                    end
                end
                if (acc) begin
                    e.rs1     = bus.in_rs1_addr;
                    e.rs2     = bus.in_rs2_addr;
                    e.rd      = bus.in_rd_addr;
                    e.use_imm = bus.in_use_imm;
                    e.sel     = (bus.in_sel == 2'b11) ? 2'b10 : bus.in_sel;
                    e.a       = fwd_pick(e.rs1, bus.in_rs1_data);
                    e.b       = e.use_imm ? bus.in_imm : fwd_pick(e.rs2, bus.in_rs2_data);
                    q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] imm, input bit ui,
                             input logic [1:0] sel, input logic [4:0] rd);
        bus.in_valid    = 1'b1;
        bus.in_rs1_addr = rs1;
        bus.in_rs2_addr = rs2;
        bus.in_rs1_data = d1;
        bus.in_rs2_data = d2;
        bus.in_imm      = imm;
        bus.in_use_imm  = ui;
        bus.in_sel      = sel;
        bus.in_rd_addr  = rd;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_A"}, bus.A, 32'd0);
        check({tag, "_B"}, bus.B, 32'd0);
        check({tag, "_Sel"}, 32'(bus.Sel), 32'd0);
        check({tag, "_rd"}, 32'(bus.out_rd_addr), 32'd0);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        set_entry(5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 5'd0);
        bus.in_valid = 1'b0;

        // reset
        step();
        started = 1'b1;
        check_reset_outputs("reset");
        step();
        rst = 1'b0;

        // single entry, OR
        bus.out_ready = 1'b1;
        set_entry(5'd1, 5'd2, 32'h0000_00F0, 32'h0000_0F0F, 32'h0, 1'b0, 2'b01, 5'd3);
        step();
        bus.in_valid = 1'b0;
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_A", bus.A, 32'h0000_00F0);
        check("single_B", bus.B, 32'h0000_0F0F);
        check("single_Sel", 32'(bus.Sel), 32'd1);
        step();

        // back-pressure: three offered, two taken
        bus.out_ready = 1'b0;
        set_entry(5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 1'b0, 2'b00, 5'd10);
        step();
        set_entry(5'd1, 5'd2, 32'h3, 32'h4, 32'h0, 1'b0, 2'b01, 5'd11);
        step();
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        set_entry(5'd1, 5'd2, 32'h5, 32'h6, 32'h0, 1'b0, 2'b10, 5'd12);
        step();
        check("bp_in_ready_still_low", 32'(bus.in_ready), 32'd0);
        check("bp_first_rd", 32'(bus.out_rd_addr), 32'd10);
        bus.out_ready = 1'b1;
        step();
        check("bp_second_rd", 32'(bus.out_rd_addr), 32'd11);
        check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
        step();
        check("bp_third_rd", 32'(bus.out_rd_addr), 32'd12);
        bus.in_valid = 1'b0;
        step();
        check("bp_empty", 32'(bus.out_valid), 32'd0);

        // capture-time forwarding
        set_entry(5'd5, 5'd6, 32'h1111_1111, 32'h2222_2222, 32'h0, 1'b0, 2'b00, 5'd4);
        fwd_valid = 1'b1; fwd_rd_addr = 5'd5; fwd_data = 32'hDEAD_BEEF;
        step();
        check("capfwd_A", bus.A, 32'hDEAD_BEEF);
        set_entry(5'd0, 5'd6, 32'h3333_3333, 32'h2222_2222, 32'h0, 1'b0, 2'b00, 5'd4);
        fwd_rd_addr = 5'd0;
        step();
        fwd_valid = 1'b0;
        bus.in_valid = 1'b0;
        check("capfwd_x0_A", bus.A, 32'h3333_3333);
        step();

        // stalled snoop on rs2
        bus.out_ready = 1'b0;
        set_entry(5'd1, 5'd7, 32'h0, 32'hAAAA_0000, 32'h0, 1'b0, 2'b00, 5'd8);
        step();
        bus.in_valid = 1'b0;
        check("snoop_B_before", bus.B, 32'hAAAA_0000);
        fwd_valid = 1'b1; fwd_rd_addr = 5'd7; fwd_data = 32'h1234_5678;
        step();
        fwd_valid = 1'b0;
        check("snoop_B_after", bus.B, SNOOP ? 32'h1234_5678 : 32'hAAAA_0000);
        bus.out_ready = 1'b1;
        step();

        // stalled entry with immediate is never replaced
        bus.out_ready = 1'b0;
        set_entry(5'd1, 5'd7, 32'h0, 32'hAAAA_0000, 32'h0000_0ABC, 1'b1, 2'b00, 5'd9);
        step();
        bus.in_valid = 1'b0;
        fwd_valid = 1'b1; fwd_rd_addr = 5'd7; fwd_data = 32'h1234_5678;
        step();
        fwd_valid = 1'b0;
        check("snoop_imm_B", bus.B, 32'h0000_0ABC);
        bus.out_ready = 1'b1;
        step();

        // flush with both buffers full and a new entry offered
        bus.out_ready = 1'b0;
        set_entry(5'd1, 5'd2, 32'h7, 32'h8, 32'h0, 1'b0, 2'b00, 5'd20);
        step();
        set_entry(5'd1, 5'd2, 32'h9, 32'hA, 32'h0, 1'b0, 2'b00, 5'd21);
        step();
        set_entry(5'd1, 5'd2, 32'hB, 32'hC, 32'h0, 1'b0, 2'b00, 5'd22);
        flush = 1'b1;
        #1;
        check("flush_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        step();
        step();
        check("flush_nothing_after", 32'(bus.out_valid), 32'd0);

        // select 11 folds to AND
        set_entry(5'd1, 5'd2, 32'hF, 32'hF, 32'h0, 1'b0, 2'b11, 5'd13);
        step();
        bus.in_valid = 1'b0;
        check("sel11_Sel", 32'(bus.Sel), 32'd2);
        step();

        // reset in the middle of a stall
        bus.out_ready = 1'b0;
        set_entry(5'd1, 5'd2, 32'h55, 32'h66, 32'h0, 1'b0, 2'b01, 5'd25);
        step();
        set_entry(5'd1, 5'd2, 32'h77, 32'h88, 32'h0, 1'b0, 2'b01, 5'd26);
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        check_reset_outputs("midrst");
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        step();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.in_rs1_addr = 5'($urandom_range(0, 7));
            bus.in_rs2_addr = 5'($urandom_range(0, 7));
            bus.in_rs1_data = $urandom();
            bus.in_rs2_data = $urandom();
            bus.in_imm      = $urandom();
            bus.in_use_imm  = ($urandom_range(0, 3) == 0);
            bus.in_sel      = 2'($urandom_range(0, 3));
            bus.in_rd_addr  = 5'($urandom_range(0, 31));
            fwd_valid       = ($urandom_range(0, 2) == 0);
            fwd_rd_addr     = 5'($urandom_range(0, 7));
            fwd_data        = $urandom();
            bus.out_ready   = ($urandom_range(0, 4) > 1);
            flush           = ($urandom_range(0, 40) == 0);
            rst             = ($urandom_range(0, 150) == 0);
            step();
        end

        // drain
        bus.in_valid = 1'b0;
        fwd_valid = 1'b0;
        flush = 1'b0;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) step();
        check("final_queue_empty", 32'(q.size()), 32'd0);
        check("final_out_valid", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
